// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer between the memory stage and a word-only data memory.
// Turns RV32I byte/half/word requests into word reads and writes, extracts and
// extends load data, merges sub-word stores (read-modify-write), and reports
// misaligned and out-of-range requests without touching memory.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; checks it for faults/misalignment
// RD_REQ  | issue the word read once memory is ready
// RD_WAIT | wait for the memory busy cycle to pass, then take the read data
// WR      | issue the word write once memory is ready
// RESP    | one-cycle completion pulse
module dmem_lsu_ctrl #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // First byte address past the end of the data memory.
  localparam logic [32:0] ADDR_LIMIT = 33'(DMEM_WORDS) << 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic        busy_seen_q, busy_seen_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;

  logic        req_fault;
  logic        req_mis;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return f3 <= 3'd2;
    end
    return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    res = {{24{b[7]}}, b};
      3'd1:    res = {{16{h[15]}}, h};
      3'd4:    res = {24'd0, b};
      3'd5:    res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Only SB (funct3[0]=0) and SH (funct3[0]=1) ever reach the merge path.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic        is_half,
                                              input logic [15:0] wd);
    logic [31:0] res;
    res = word;
    if (is_half) begin
      if (off[1]) res[31:16] = wd;
      else        res[15:0]  = wd;
    end else begin
      case (off)
        2'd0:    res[7:0]   = wd[7:0];
        2'd1:    res[15:8]  = wd[7:0];
        2'd2:    res[23:16] = wd[7:0];
        default: res[31:24] = wd[7:0];
      endcase
    end
    return res;
  endfunction

  // Request error decode; fault takes priority over misalignment.
  always_comb begin
    req_fault = !f3_legal(req_we, req_funct3) || ({1'b0, req_addr} >= ADDR_LIMIT);
    req_mis   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    busy_seen_d = busy_seen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    mis_d       = mis_q;
    fault_d     = fault_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata[15:0];
          if (req_fault || req_mis) begin
            rdata_d = 32'd0;
            fault_d = req_fault;
            mis_d   = !req_fault && req_mis;
            state_d = S_RESP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_we && (req_funct3 == 3'd2)) begin
              mem_wdata_d = req_wdata;
              state_d     = S_WR;
            end else begin
              state_d = S_RD_REQ;
            end
          end
        end
      end

      S_RD_REQ: begin
        mem_read    = mem_ready;
        busy_seen_d = 1'b0;
        if (mem_ready) state_d = S_RD_WAIT;
      end

      // The memory drops ready for one cycle after a read; data is only
      // valid once ready returns, so wait for the busy cycle first.
      S_RD_WAIT: begin
        if (!mem_ready) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          busy_seen_d = 1'b0;
          if (we_q) begin
            mem_wdata_d = store_merge(mem_rdata, off_q, f3_q[0], wdata_q);
            state_d     = S_WR;
          end else begin
            rdata_d = load_extract(mem_rdata, off_q, f3_q);
            mis_d   = 1'b0;
            fault_d = 1'b0;
            state_d = S_RESP;
          end
        end
      end

      S_WR: begin
        mem_write = mem_ready;
        if (mem_ready) begin
          rdata_d = 32'd0;
          mis_d   = 1'b0;
          fault_d = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      wdata_q     <= 16'd0;
      busy_seen_q <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      mis_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      wdata_q     <= wdata_d;
      busy_seen_q <= busy_seen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
    end
  end

  assign resp_rdata      = rdata_q;
  assign resp_misaligned = mis_q;
  assign resp_fault      = fault_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Bench for dmem_lsu_ctrl: a word memory with a one-cycle busy after each read,
// and a byte-array reference model that predicts response data, error flags,
// latency and memory traffic for every request.
module tb_dmem_lsu_ctrl;

  localparam int DMEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  int checks = 0;
  int errors = 0;

  dmem_lsu_ctrl #(.DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  // Data memory: reads return data after one busy cycle, writes are immediate.
  logic [31:0] bmem [0:DMEM_WORDS-1];
  logic        busy = 1'b0;
  bit          init_done = 1'b0;
  logic [31:0] mrdata = 32'd0;
  assign mem_ready = !busy;
  assign mem_rdata = mrdata;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int w = 0; w < DMEM_WORDS; w++) bmem[w] <= init_word(w);
      init_done <= 1'b1;
    end else begin
      if (mem_read) begin
        mrdata <= bmem[mem_addr[9:2]];
        busy   <= 1'b1;
      end else begin
        busy <= 1'b0;
      end
      if (mem_write) bmem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  // Reference: flat little-endian byte memory.
  logic [7:0] refmem [0:4*DMEM_WORDS-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                            output logic fault, output int lat, output int nrd, output int nwr);
    bit legal;
    int size;
    logic [31:0] val;
    legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    fault = !legal || (addr >= 32'(4 * DMEM_WORDS));
    size  = 1 << f3[1:0];
    mis   = !fault && ((addr % 32'(size)) != 0);
    rd = 32'd0; lat = 1; nrd = 0; nwr = 0;
    if (!fault && !mis) begin
      if (we) begin
        for (int b = 0; b < size; b++) refmem[int'(addr) + b] = wd[8*b +: 8];
        lat = (size == 4) ? 2 : 5;
        nrd = (size == 4) ? 0 : 1;
        nwr = 1;
      end else begin
        val = 32'd0;
        for (int b = 0; b < size; b++) val = val | (32'(refmem[int'(addr) + b]) << (8 * b));
        if (!f3[2] && size < 4 && val[8*size-1]) val = val - (32'd1 << (8 * size));
        rd  = val;
        lat = 4;
        nrd = 1;
      end
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = v; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
  endtask

  // Request already on the bus; after acceptance the next request (or idle) is driven.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd, input logic nv, input logic nwe,
                     input logic [2:0] nf3, input logic [31:0] naddr, input logic [31:0] nwd);
    logic [31:0] e_rd, wr_addr;
    logic e_mis, e_fault;
    int e_lat, e_nrd, e_nwr, n, lat, nrd, nwr;
    bit got, early;
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    chk("accept_ready", 32'(req_ready), 32'd1);
    ref_access(we, f3, addr, wd, e_rd, e_mis, e_fault, e_lat, e_nrd, e_nwr);
    @(posedge clk); #1;
    drive(nv, nwe, nf3, naddr, nwd);
    lat = 0; nrd = 0; nwr = 0; got = 0; early = 0; wr_addr = 32'd0;
    while (!got && lat < 30) begin
      @(negedge clk); lat++;
      chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        wr_addr = mem_addr;
        if (nrd == 0 && e_nrd != 0) early = 1;
      end
      if (resp_valid) got = 1;
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("resp_rdata", resp_rdata, e_rd);
    chk("resp_misaligned", 32'(resp_misaligned), 32'(e_mis));
    chk("resp_fault", 32'(resp_fault), 32'(e_fault));
    chk("read_count", 32'(nrd), 32'(e_nrd));
    chk("write_count", 32'(nwr), 32'(e_nwr));
    chk("write_before_read", 32'(early), 32'd0);
    if (e_nwr != 0) chk("write_addr", wr_addr, {addr[31:2], 2'b00});
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
  endtask

  task automatic one(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    drive(1'b1, we, f3, addr, wd);
    txn(we, f3, addr, wd, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_resp_mis"}, 32'(resp_misaligned), 32'd0);
    chk({tag, "_resp_fault"}, 32'(resp_fault), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
  endtask

  initial begin
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr, rwd;
    logic [31:0] b_addr [0:19];
    logic [31:0] b_wd   [0:19];
    int          wcnt;

    for (int w = 0; w < DMEM_WORDS; w++)
      for (int b = 0; b < 4; b++) refmem[4*w + b] = init_word(w) >> (8 * b);

    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: word store/load, extraction, sub-word stores, errors.
    one(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    one(1'b0, 3'd2, 32'h10, 32'd0);
    chk("lw_deadbeef", resp_rdata, 32'hDEADBEEF);
    one(1'b0, 3'd0, 32'h13, 32'd0);
    chk("lb_sext", resp_rdata, 32'hFFFFFFDE);
    one(1'b0, 3'd4, 32'h13, 32'd0);
    chk("lbu_zext", resp_rdata, 32'h000000DE);
    one(1'b0, 3'd1, 32'h10, 32'd0);
    chk("lh_sext", resp_rdata, 32'hFFFFBEEF);
    one(1'b0, 3'd5, 32'h12, 32'd0);
    chk("lhu_zext", resp_rdata, 32'h0000DEAD);
    one(1'b1, 3'd0, 32'h11, 32'hFFFFFF55);
    one(1'b0, 3'd2, 32'h10, 32'd0);
    chk("sb_merge", resp_rdata, 32'hDEAD55EF);
    one(1'b1, 3'd1, 32'h12, 32'hABCD1234);
    one(1'b0, 3'd2, 32'h10, 32'd0);
    chk("sh_merge", resp_rdata, 32'h123455EF);
    one(1'b0, 3'd2, 32'h06, 32'd0);
    chk("lw_mis", 32'(resp_misaligned), 32'd1);
    one(1'b1, 3'd1, 32'h03, 32'h1111);
    chk("sh_mis", 32'(resp_misaligned), 32'd1);
    one(1'b0, 3'd2, 32'h400, 32'd0);
    chk("lw_range", 32'(resp_fault), 32'd1);
    one(1'b0, 3'd3, 32'h20, 32'd0);
    chk("ld_f3_illegal", 32'(resp_fault), 32'd1);
    one(1'b1, 3'd3, 32'h20, 32'h0);
    one(1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D);
    one(1'b0, 3'd2, 32'h3FC, 32'd0);
    one(1'b0, 3'd1, 32'h3FF, 32'd0);
    one(1'b0, 3'd2, 32'h402, 32'd0);

    // Reset during the read phase of an SB: no response, no write.
    drive(1'b1, 1'b1, 3'd0, 32'h21, 32'hAA);
    wcnt = 0;
    while (!req_ready) @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    @(negedge clk); if (mem_write) wcnt++;
    @(negedge clk); if (mem_write) wcnt++;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (mem_write || resp_valid) wcnt++; end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (mem_write || resp_valid) wcnt++; end
    chk("abort_no_write", 32'(wcnt), 32'd0);
    one(1'b0, 3'd2, 32'h20, 32'd0);
    chk("abort_word_kept", resp_rdata, init_word(8));

    // Randomized mix of widths, offsets and error cases.
    for (int i = 0; i < 60; i++) begin
      rwe = 1'($urandom_range(0, 1));
      rf3 = 3'($urandom_range(0, 7));
      if (rwe && $urandom_range(0, 3) != 0) rf3 = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       raddr = $urandom;
        1:       raddr = 32'($urandom_range(1016, 1031));
        default: raddr = 32'($urandom_range(0, 63));
      endcase
      rwd = $urandom;
      one(rwe, rf3, raddr, rwd);
    end

    // Back-to-back: req_valid held high, alternating SW / LW of the same word.
    for (int i = 0; i < 20; i++) begin
      b_addr[i] = (i % 2 == 0) ? {22'd0, 8'($urandom_range(0, 255)), 2'b00} : b_addr[i-1];
      b_wd[i]   = $urandom;
    end
    drive(1'b1, 1'b1, 3'd2, b_addr[0], b_wd[0]);
    for (int i = 0; i < 20; i++) begin
      if (i < 19)
        txn(1'(i % 2 == 0), 3'd2, b_addr[i], b_wd[i],
            1'b1, 1'((i + 1) % 2 == 0), 3'd2, b_addr[i+1], b_wd[i+1]);
      else
        txn(1'(i % 2 == 0), 3'd2, b_addr[i], b_wd[i],
            1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      if (i % 2 == 1) chk("b2b_order", resp_rdata, b_wd[i-1]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
- Load/store sequencer between the core's memory stage and the word-only data memory (256 x 32, word-indexed by addr[31:2], 1-cycle-busy reads, immediate writes).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses on that memory.
- Performs byte/halfword extraction with sign/zero extension on loads and read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses instead of touching memory.

Parameters:
- DMEM_WORDS, 256, number of 32-bit words in the data memory; byte addresses >= 4*DMEM_WORDS are access faults.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (1 only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for SB/SH
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load result; 0 for stores and errors
- resp_misaligned  out  1  valid with resp_valid
- resp_fault  out  1  valid with resp_valid; out of range or illegal funct3
- mem_addr  out  32  {word address, 2'b00} to memory
- mem_wdata  out  32  word to write
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_rdata  in  32  memory read_data
- mem_ready  in  1  memory ready (0 = busy)

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_misaligned=0; resp_fault=0; mem_addr=0; mem_wdata=0; mem_read=0; mem_write=0; busy_seen=0.
- Reset mid-transaction aborts it with no response. A partially done SB/SH RMW never writes.
- Accept: req_valid & req_ready at a rising edge. Capture addr, we, funct3, wdata.
- Error checks at accept, with priority fault > misaligned:
  - fault: illegal funct3 (load 3/6/7; store 3..7) or addr >= 4*DMEM_WORDS.
  - misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=0.
  - On error go to RESP. No memory access occurs.
- States: IDLE, RD_REQ, RD_WAIT, WR, RESP.
- IDLE:
  - Aligned load or SB/SH -> RD_REQ.
  - SW -> WR.
- RD_REQ:
  - mem_read = mem_ready (combinational). Hold while mem_ready=0; this covers memory still busy after reset.
  - On an edge with mem_ready=1 -> RD_WAIT.
- RD_WAIT:
  - mem_read=0. Set busy_seen when mem_ready=0.
  - When busy_seen=1 and mem_ready=1, capture mem_rdata, clear busy_seen, then:
    - load -> RESP, with resp_rdata the extracted value.
    - SB/SH -> WR, with the merged word in mem_wdata.
- WR:
  - mem_write = mem_ready. Hold until mem_ready=1.
  - After the write edge -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_* hold their value until the next RESP.
- mem_addr = {addr[31:2],2'b00}, held constant from RD_REQ through WR. mem_read and mem_write are never both 1.
- Little-endian. Byte k = word[8k+7:8k], k = addr[1:0]. Half = word[31:16] if addr[1] else word[15:0].
- Load extraction: LB/LH sign-extend; LBU/LHU zero-extend; LW returns the word unchanged.
- Store merge: SB replaces byte k with wdata[7:0]. SH replaces the selected half with wdata[15:0]. Other bytes come from the read word.
- Latency with an idle memory, counted from the accept edge:
  - load: 4 cycles (RD_REQ, RD_WAIT busy, RD_WAIT ready, RESP)
  - SB/SH: 5 cycles
  - SW: 2 cycles
  - error: 1 cycle
- No response backpressure. req_valid during a transaction is ignored because req_ready=0.

Test Plan:
- SW addr 0x10 data 0xDEADBEEF -> one mem_write, mem_addr=0x10; then LW 0x10 -> resp_rdata=0xDEADBEEF, resp_valid exactly 4 cycles after accept.
- With word 0x10 = 0xDEADBEEF, loads give: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x55 on 0xDEADBEEF -> memory word 0xDEAD55EF; SH 0x12 data 0x1234 -> 0x123455EF. Neither store may issue a write before its read completes.
- Error responses, each 1 cycle after accept with mem_read=mem_write=0 throughout:
  - LW 0x06 -> resp_misaligned=1, resp_fault=0.
  - SH 0x03 -> resp_misaligned=1.
  - LW 0x400 (DMEM_WORDS=256) -> resp_fault=1.
  - Load funct3=3 -> resp_fault=1.
- Assert rst_n low during RD_WAIT of an SB -> outputs return to reset values immediately; no mem_write ever occurs; the next LW returns the unmodified word.
- Back-to-back: hold req_valid=1 with alternating SW and LW -> each request is accepted only when req_ready=1, exactly one resp_valid per request, responses in request order.
